// File: rtl/leg_sel_decoder.sv
// Registered one-hot decoder with a valid/ready handshake on both sides.
// A selector field is picked out of each accepted word and decoded into out.
module leg_sel_decoder #(
  parameter int IN_W    = 8,
  parameter int SEL_W   = 3,
  parameter int SEL_LSB = 0,
  parameter int PULSE   = 0,
  parameter int STRICT  = 0,
  localparam int OUT_N  = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  Input,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             dis,
  output logic [OUT_N-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic [15:0]      xfer_cnt
);

  logic [SEL_W-1:0] sel;
  logic             viol;
  logic [OUT_N-1:0] onehot;
  logic [OUT_N-1:0] decode_next;
  logic             accept;
  logic             transfer;
  logic             unused_in;

  logic [OUT_N-1:0] out_reg;
  logic             out_valid_reg;
  logic             err_reg;
  logic [15:0]      xfer_cnt_reg;

  assign sel       = Input[SEL_LSB +: SEL_W];
  assign unused_in = ^Input;

  // Bits above the selector only matter in strict mode, and only if any exist.
  generate
    if (STRICT != 0 && SEL_LSB + SEL_W < IN_W) begin : g_strict
      assign viol = |Input[IN_W-1:SEL_LSB+SEL_W];
    end else begin : g_lax
      assign viol = 1'b0;
    end
  endgenerate

  for (genvar gi = 0; gi < OUT_N; gi++) begin : g_dec
    assign onehot[gi] = (sel == SEL_W'(gi));
  end

  assign decode_next = (dis || viol) ? '0 : onehot;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid_reg && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      xfer_cnt_reg  <= 16'd0;
    end else begin
      if (transfer) begin
        xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
      end
      // A same-edge accept replaces the word being transferred, so no bubble.
      if (accept) begin
        out_reg       <= decode_next;
        err_reg       <= viol;
        out_valid_reg <= 1'b1;
      end else if (transfer) begin
        out_valid_reg <= 1'b0;
        if (PULSE != 0) begin
          out_reg <= '0;
        end
      end
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign err       = err_reg;
  assign xfer_cnt  = xfer_cnt_reg;

endmodule

// File: tb/tb_leg_sel_decoder.sv
// Bench for leg_sel_decoder: three parameterisations share one stimulus stream
// and are compared against a rule-level reference model.
module tb_leg_sel_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       in_valid;
  logic       dis;
  logic       out_ready;

  logic [7:0]  out0, out1;
  logic [15:0] out2;
  logic        v0, v1, v2, r0, r1, r2, e0, e1, e2;
  logic [15:0] c0, c1, c2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: STRICT, 2: PULSE with a 4-bit selector in the upper nibble
  leg_sel_decoder dut0 (
    .clk(clk), .rst(rst), .Input(din), .in_valid(in_valid), .in_ready(r0), .dis(dis),
    .out(out0), .out_valid(v0), .out_ready(out_ready), .err(e0), .xfer_cnt(c0));

  leg_sel_decoder #(.STRICT(1)) dut1 (
    .clk(clk), .rst(rst), .Input(din), .in_valid(in_valid), .in_ready(r1), .dis(dis),
    .out(out1), .out_valid(v1), .out_ready(out_ready), .err(e1), .xfer_cnt(c1));

  leg_sel_decoder #(.IN_W(8), .SEL_W(4), .SEL_LSB(4), .PULSE(1)) dut2 (
    .clk(clk), .rst(rst), .Input(din), .in_valid(in_valid), .in_ready(r2), .dis(dis),
    .out(out2), .out_valid(v2), .out_ready(out_ready), .err(e2), .xfer_cnt(c2));

  logic [15:0] d_out[3];
  logic        d_valid[3];
  logic        d_rdy[3];
  logic        d_err[3];
  logic [15:0] d_cnt[3];

  assign d_out[0] = {8'h00, out0};
  assign d_out[1] = {8'h00, out1};
  assign d_out[2] = out2;
  assign d_valid[0] = v0;
  assign d_valid[1] = v1;
  assign d_valid[2] = v2;
  assign d_rdy[0] = r0;
  assign d_rdy[1] = r1;
  assign d_rdy[2] = r2;
  assign d_err[0] = e0;
  assign d_err[1] = e1;
  assign d_err[2] = e2;
  assign d_cnt[0] = c0;
  assign d_cnt[1] = c1;
  assign d_cnt[2] = c2;

  int p_lsb[3]    = '{0, 0, 4};
  int p_w[3]      = '{3, 3, 4};
  int p_strict[3] = '{0, 1, 0};
  int p_pulse[3]  = '{0, 0, 1};

  logic        m_valid[3];
  logic [15:0] m_out[3];
  logic        m_err[3];
  logic [15:0] m_cnt[3];

  function automatic logic exp_viol(input int i, input logic [7:0] d);
    return (p_strict[i] != 0) && ((int'(d) >> (p_lsb[i] + p_w[i])) != 0);
  endfunction

  function automatic logic [15:0] exp_word(input int i, input logic [7:0] d, input logic ds);
    int s;
    s = (int'(d) >> p_lsb[i]) % (1 << p_w[i]);
    if (ds || exp_viol(i, d)) return 16'h0000;
    return 16'(1 << s);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0;
      m_out[i]   = 16'h0;
      m_err[i]   = 1'b0;
      m_cnt[i]   = 16'h0;
    end
  endtask

  // Advance the model by one edge using the currently driven inputs, then
  // move to the next falling edge where outputs are sampled.
  task automatic tick();
    logic acc, xfr;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_valid[i] = 1'b0;
        m_out[i]   = 16'h0;
        m_err[i]   = 1'b0;
        m_cnt[i]   = 16'h0;
      end else begin
        acc = in_valid && (!m_valid[i] || out_ready);
        xfr = m_valid[i] && out_ready;
        if (xfr) m_cnt[i] = m_cnt[i] + 16'd1;
        if (acc) begin
          m_out[i]   = exp_word(i, din, dis);
          m_err[i]   = exp_viol(i, din);
          m_valid[i] = 1'b1;
        end else if (xfr) begin
          m_valid[i] = 1'b0;
          if (p_pulse[i] != 0) m_out[i] = 16'h0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 8'h00; in_valid = 1'b0; dis = 1'b0; out_ready = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (d_out[i] !== 16'h0 || d_valid[i] !== 1'b0 || d_err[i] !== 1'b0 || d_cnt[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset_state inst%0d: out=%h valid=%b err=%b cnt=%h, required all zero",
                 i, d_out[i], d_valid[i], d_err[i], d_cnt[i]);
      end
      checks++;
      if (d_rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready inst%0d: got %b required 1", i, d_rdy[i]);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (r0 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready: got %b required 1", r0);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    din = 8'h05; in_valid = 1'b1; dis = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (out0 !== 8'h20 || v0 !== 1'b1) begin
      errors++;
      $display("FAIL basic_first_accept: out=%h valid=%b required out=20 valid=1", out0, v0);
    end
    checks++;
    if (out2 !== 16'h0001 || v2 !== 1'b1) begin
      errors++;
      $display("FAIL basic_pulse_load: out=%h valid=%b required out=0001 valid=1", out2, v2);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (v0 !== 1'b0 || out0 !== 8'h20 || c0 !== 16'd1) begin
      errors++;
      $display("FAIL basic_level_hold: valid=%b out=%h cnt=%0d required valid=0 out=20 cnt=1", v0, out0, c0);
    end
    checks++;
    if (v2 !== 1'b0 || out2 !== 16'h0000 || c2 !== 16'd1) begin
      errors++;
      $display("FAIL basic_pulse_clear: valid=%b out=%h cnt=%0d required valid=0 out=0000 cnt=1", v2, out2, c2);
    end
    $display("test_basic done");
  endtask

  task automatic test_backpressure();
    logic [15:0] cnt0;
    cnt0 = c0;
    out_ready = 1'b0; din = 8'h02; in_valid = 1'b1; dis = 1'b0;
    tick();
    din = 8'h07;
    #1;
    checks++;
    if (r0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready_low: got %b required 0", r0);
    end
    tick();
    tick();
    checks++;
    if (out0 !== 8'h04 || v0 !== 1'b1 || c0 !== cnt0) begin
      errors++;
      $display("FAIL bp_hold: out=%h valid=%b cnt=%0d required out=04 valid=1 cnt=%0d", out0, v0, c0, cnt0);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (r0 !== 1'b1) begin
      errors++;
      $display("FAIL bp_in_ready_high: got %b required 1", r0);
    end
    tick();
    checks++;
    if (out0 !== 8'h80 || v0 !== 1'b1 || c0 !== cnt0 + 16'd1) begin
      errors++;
      $display("FAIL bp_swap: out=%h valid=%b cnt=%0d required out=80 valid=1 cnt=%0d",
               out0, v0, c0, cnt0 + 16'd1);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (v0 !== 1'b0 || c0 !== cnt0 + 16'd2) begin
      errors++;
      $display("FAIL bp_drain: valid=%b cnt=%0d required valid=0 cnt=%0d", v0, c0, cnt0 + 16'd2);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_strict();
    out_ready = 1'b1; in_valid = 1'b1; dis = 1'b0; din = 8'h13;
    tick();
    checks++;
    if (out1 !== 8'h00 || e1 !== 1'b1 || v1 !== 1'b1) begin
      errors++;
      $display("FAIL strict_violation: out=%h err=%b valid=%b required out=00 err=1 valid=1", out1, e1, v1);
    end
    checks++;
    if (out0 !== 8'h08 || e0 !== 1'b0) begin
      errors++;
      $display("FAIL lax_ignores_upper: out=%h err=%b required out=08 err=0", out0, e0);
    end
    din = 8'h03;
    tick();
    checks++;
    if (out1 !== 8'h08 || e1 !== 1'b0) begin
      errors++;
      $display("FAIL strict_clean: out=%h err=%b required out=08 err=0", out1, e1);
    end
    in_valid = 1'b0;
    tick();
    $display("test_strict done");
  endtask

  task automatic test_pulse();
    out_ready = 1'b1; in_valid = 1'b1; dis = 1'b0; din = 8'hA0;
    tick();
    checks++;
    if (out2 !== 16'h0400 || v2 !== 1'b1) begin
      errors++;
      $display("FAIL pulse_load: out=%h valid=%b required out=0400 valid=1", out2, v2);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out2 !== 16'h0000 || v2 !== 1'b0 || out0 !== 8'h01) begin
      errors++;
      $display("FAIL pulse_clear: out2=%h valid=%b out0=%h required out2=0000 valid=0 out0=01", out2, v2, out0);
    end
    dis = 1'b1; in_valid = 1'b1;
    tick();
    checks++;
    if (out2 !== 16'h0000 || v2 !== 1'b1 || out0 !== 8'h00 || v0 !== 1'b1) begin
      errors++;
      $display("FAIL disable: out2=%h v2=%b out0=%h v0=%b required zeros with valid=1", out2, v2, out0, v0);
    end
    dis = 1'b0; in_valid = 1'b0;
    tick();
    $display("test_pulse done");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; din = 8'h05; in_valid = 1'b1; dis = 1'b0;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (d_out[i] !== 16'h0 || d_valid[i] !== 1'b0 || d_cnt[i] !== 16'h0 || d_rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL async_reset inst%0d: out=%h valid=%b cnt=%h ready=%b required 0/0/0/1",
                 i, d_out[i], d_valid[i], d_cnt[i], d_rdy[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (c0 !== 16'h0 || v0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: cnt=%0d valid=%b required cnt=0 valid=0", c0, v0);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      dis       = ($urandom_range(0, 7) == 0);
      din       = 8'($urandom);
      if (rst) model_clear();
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (d_rdy[i] !== (!m_valid[i] || out_ready)) begin
          errors++;
          $display("FAIL rand_in_ready inst%0d cyc%0d: got %b required %b",
                   i, n, d_rdy[i], (!m_valid[i] || out_ready));
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (d_out[i] !== m_out[i] || d_valid[i] !== m_valid[i] || d_err[i] !== m_err[i] || d_cnt[i] !== m_cnt[i]) begin
          errors++;
          $display("FAIL rand_outputs inst%0d cyc%0d: out=%h valid=%b err=%b cnt=%h required %h %b %b %h",
                   i, n, d_out[i], d_valid[i], d_err[i], d_cnt[i], m_out[i], m_valid[i], m_err[i], m_cnt[i]);
        end
      end
    end
    rst = 1'b0;
    $display("test_random done");
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; dis = 1'b0;
    for (int k = 1; k <= 65537; k++) begin
      din = 8'($urandom);
      #1;
      checks++;
      if (r0 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_stall edge%0d: in_ready=%b required 1", k, r0);
      end
      tick();
      if (k == 65536) begin
        checks++;
        if (c0 !== 16'hFFFF) begin
          errors++;
          $display("FAIL b2b_pre_wrap: cnt=%h required ffff", c0);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (d_cnt[i] !== 16'h0000 || d_valid[i] !== 1'b1 || d_out[i] !== m_out[i]) begin
        errors++;
        $display("FAIL b2b_wrap inst%0d: cnt=%h valid=%b out=%h required cnt=0000 valid=1 out=%h",
                 i, d_cnt[i], d_valid[i], d_out[i], m_out[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_strict();
    test_pulse();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
